// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong game blocks.
//   pong_state_e : match controller FSM encoding (also exported on the debug port)
//   MID_Y_ROW    : screen row that splits the top half from the bottom half
//   TOP_LIMIT    : top wall row used by the ball and paddle blocks
//   BOTTOM_LIMIT : bottom wall row used by the ball and paddle blocks
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } pong_state_e;

  localparam int MID_Y_ROW    = 278;
  localparam int TOP_LIMIT    = 40;
  localparam int BOTTOM_LIMIT = 515;

endpackage

// File: rtl/pong_tick_div.sv
// pong_tick_div: enable-gated modulo-DIV counter.
//   clk, rst_n : clock, async active-low reset
//   en         : advance the count this cycle
//   clr        : synchronous clear of count and tick (wins over en)
//   tc         : combinational terminal count (count at DIV-1 while enabled)
//   tick       : registered one-cycle pulse, high in the cycle after tc
module pong_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tc = en & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tc;
      if (en) begin
        cnt <= tc ? '0 : cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencing for the pong ball axis.
//   clk, rst_n : clock, async active-low reset
//   start      : debounced start button (level, rising edge used)
//   pause      : freezes ball stepping while in PLAY
//   ball_fell  : one-cycle pulse, ball left the field
//   ball_top   : ball top row, decides which player scored
//   ball_tick  : one-cycle ball step enable
//   ball_rst   : hold ball at centre
//   score_p1/2 : player scores (p1 = top paddle, p2 = bottom paddle)
//   game_over  : match finished
//   winner     : 0 = p1, 1 = p2, valid with game_over
//   state      : FSM state for debug
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int SERVE_CYCLES = 25000000,
  parameter int WIN_SCORE    = 9,
  parameter int MID_Y        = MID_Y_ROW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        ball_fell,
  input  logic [15:0] ball_top,
  output logic        ball_tick,
  output logic        ball_rst,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state
);

  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

  pong_state_e state_q, state_d;
  logic        start_q;
  logic        start_rise;
  logic        start_clr;
  logic        fell_acc;
  logic        p2_scores;
  logic [3:0]  p1_inc, p2_inc;
  logic        win_hit;
  logic        step_en;
  logic        serve_en, serve_clr, serve_tc;
  logic        step_tc_unused, serve_tick_unused;

  assign start_rise = start & ~start_q;
  assign start_clr  = start_rise & ((state_q == IDLE) | (state_q == OVER));
  assign fell_acc   = ball_fell & (state_q == PLAY);
  // A ball above the midline exited past the top paddle: bottom player scores.
  assign p2_scores  = ball_top < 16'(MID_Y);
  assign p1_inc     = score_p1 + 4'd1;
  assign p2_inc     = score_p2 + 4'd1;
  assign win_hit    = p2_scores ? (p2_inc == WIN4) : (p1_inc == WIN4);

  // Gating the divider with ball_fell suppresses a tick that would
  // otherwise coincide with the point being scored.
  assign step_en   = (state_q == PLAY) & ~pause & ~ball_fell;
  assign serve_en  = (state_q == SERVE);
  assign serve_clr = start_clr | (state_q == POINT);

  pong_tick_div #(.DIV(TICK_DIV)) u_step_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (step_en),
    .clr   (serve_tc),
    .tc    (step_tc_unused),
    .tick  (ball_tick)
  );

  pong_tick_div #(.DIV(SERVE_CYCLES)) u_serve_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (serve_en),
    .clr   (serve_clr),
    .tc    (serve_tc),
    .tick  (serve_tick_unused)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_rise) state_d = SERVE;
      SERVE:   if (serve_tc) state_d = PLAY;
      PLAY:    if (fell_acc) state_d = win_hit ? OVER : POINT;
      POINT:   state_d = SERVE;
      OVER:    if (start_rise) state_d = SERVE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      ball_rst  <= 1'b1;
      game_over <= 1'b0;
      winner    <= 1'b0;
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      ball_rst  <= (state_d == IDLE) | (state_d == POINT) | (state_d == OVER);
      game_over <= (state_d == OVER);
      if (start_clr) begin
        score_p1 <= 4'd0;
        score_p2 <= 4'd0;
        winner   <= 1'b0;
      end else if (fell_acc) begin
        if (p2_scores) score_p2 <= p2_inc;
        else           score_p1 <= p1_inc;
        if (win_hit) winner <= p2_scores;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

  localparam int TD  = 4;
  localparam int SC  = 8;
  localparam int WS  = 3;
  localparam int MID = 278;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        ball_fell = 1'b0;
  logic [15:0] ball_top = 16'd0;
  logic        ball_tick, ball_rst, game_over, winner;
  logic [3:0]  score_p1, score_p2;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  pong_match_ctrl #(
    .TICK_DIV(TD), .SERVE_CYCLES(SC), .WIN_SCORE(WS), .MID_Y(MID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .ball_fell(ball_fell), .ball_top(ball_top),
    .ball_tick(ball_tick), .ball_rst(ball_rst),
    .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 serve, 2 play, 3 point, 4 over.
  int m_phase = 0, m_wait = 0, m_div = 0, m_s1 = 0, m_s2 = 0;
  int m_tick = 0, m_brst = 1, m_go = 0, m_win = 0, m_startq = 0;

  always @(posedge clk) begin
    int rise, tick_n;
    if (!rst_n) begin
      m_phase = 0; m_wait = 0; m_div = 0; m_s1 = 0; m_s2 = 0;
      m_tick = 0; m_brst = 1; m_go = 0; m_win = 0; m_startq = 0;
    end else begin
      rise = (start && !m_startq) ? 1 : 0;
      m_startq = start ? 1 : 0;
      tick_n = 0;
      case (m_phase)
        0: if (rise) begin m_s1 = 0; m_s2 = 0; m_wait = 0; m_phase = 1; end
        1: if (m_wait == SC - 1) begin m_phase = 2; m_div = 0; end
           else m_wait++;
        2: if (ball_fell) begin
             if (int'(ball_top) < MID) begin
               m_s2++;
               if (m_s2 == WS) begin m_phase = 4; m_win = 1; end else m_phase = 3;
             end else begin
               m_s1++;
               if (m_s1 == WS) begin m_phase = 4; m_win = 0; end else m_phase = 3;
             end
           end else if (!pause) begin
             if (m_div == TD - 1) begin m_div = 0; tick_n = 1; end
             else m_div++;
           end
        3: begin m_phase = 1; m_wait = 0; end
        default: if (rise) begin m_s1 = 0; m_s2 = 0; m_wait = 0; m_phase = 1; end
      endcase
      m_tick = tick_n;
      m_brst = (m_phase == 0 || m_phase == 3 || m_phase == 4) ? 1 : 0;
      m_go   = (m_phase == 4) ? 1 : 0;
    end
    #1;
    chk("state", int'(state), m_phase);
    chk("ball_tick", int'(ball_tick), m_tick);
    chk("ball_rst", int'(ball_rst), m_brst);
    chk("score_p1", int'(score_p1), m_s1);
    chk("score_p2", int'(score_p2), m_s2);
    chk("game_over", int'(game_over), m_go);
    if (m_go == 1) chk("winner", int'(winner), m_win);
  end

  task automatic wait_state(input int s, input int budget);
    int k = 0;
    @(negedge clk);
    while (int'(state) != s && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (int'(state) != s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_state: state %0d, expected %0d within %0d cycles", state, s, budget);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fell_now(input int top);
    ball_fell = 1'b1;
    ball_top  = 16'(top);
    @(negedge clk);
    ball_fell = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    int k = 0;
    @(negedge clk);
    while (!ball_tick && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!ball_tick) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_tick: no tick within %0d cycles", budget);
    end
  endtask

  initial begin
    int k, cnt, rcnt;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_ball_rst", int'(ball_rst), 1);
    chk("rst_tick", int'(ball_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fell while idle is ignored
    fell_now(30);
    #1 chk("idle_fell_p2", int'(score_p2), 0);

    // start -> SERVE for SC cycles -> PLAY
    pulse_start();
    cnt = 0; k = 0;
    while (int'(state) != 2 && k < 50) begin
      if (int'(state) == 1) cnt++;
      if (k == 3) ball_fell = 1'b1;
      else ball_fell = 1'b0;
      @(negedge clk);
      k++;
    end
    ball_fell = 1'b0;
    chk("serve_len", cnt, SC);
    chk("serve_fell_p2", int'(score_p2), 0);

    // first tick on PLAY cycle 4, then every 4 cycles
    k = 0;
    while (!ball_tick && k < 20) begin @(negedge clk); k++; end
    chk("first_tick_ofs", k, TD);
    k = 0;
    do begin @(negedge clk); k++; end while (!ball_tick && k < 20);
    chk("tick_period", k, TD);

    // top exit -> p2 scores, one cycle of ball_rst, quiet serve
    fell_now(30);
    #1;
    chk("p2_after_fell", int'(score_p2), 1);
    chk("p1_after_fell", int'(score_p1), 0);
    chk("point_state", int'(state), 3);
    cnt = 0; rcnt = 0;
    for (int i = 0; i < SC + 1; i++) begin
      if (ball_tick) cnt++;
      if (ball_rst) rcnt++;
      @(negedge clk);
    end
    chk("quiet_ticks", cnt, 0);
    chk("rst_pulse_len", rcnt, 1);

    // pause preserves the divider
    wait_state(2, 40);
    wait_tick(20);
    @(negedge clk);
    pause = 1'b1;
    cnt = 0;
    repeat (19) begin @(negedge clk); if (ball_tick) cnt++; end
    @(negedge clk);
    pause = 1'b0;
    if (ball_tick) cnt++;
    chk("paused_ticks", cnt, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!ball_tick && k < 20);
    chk("resume_remaining", k, TD - 1);

    // fell coincident with terminal count: scored, tick suppressed
    wait_tick(20);
    repeat (TD - 1) @(negedge clk);
    fell_now(500);
    #1;
    chk("coinc_tick", int'(ball_tick), 0);
    chk("coinc_p1", int'(score_p1), 1);

    // start ignored in PLAY; midline row counts as bottom; p1 wins
    wait_state(2, 40);
    pulse_start();
    fell_now(MID);
    #1 chk("mid_row_p1", int'(score_p1), 2);
    wait_state(2, 40);
    fell_now(500);
    #1;
    chk("over_p1", int'(score_p1), 3);
    chk("over_flag", int'(game_over), 1);
    chk("over_winner", int'(winner), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      ball_fell = (i == 4);
      if (ball_tick) cnt++;
      @(negedge clk);
    end
    ball_fell = 1'b0;
    chk("over_ticks", cnt, 0);
    chk("over_frozen_p1", int'(score_p1), 3);
    pulse_start();
    #1;
    chk("restart_state", int'(state), 1);
    chk("restart_p1", int'(score_p1), 0);
    chk("restart_go", int'(game_over), 0);

    // row just above midline counts as top exit
    wait_state(2, 40);
    fell_now(MID - 1);
    #1 chk("mid_m1_p2", int'(score_p2), 1);

    // async reset mid-PLAY
    wait_state(2, 40);
    rst_n = 1'b0;
    #1;
    chk("mrst_state", int'(state), 0);
    chk("mrst_ball_rst", int'(ball_rst), 1);
    chk("mrst_p2", int'(score_p2), 0);
    chk("mrst_tick", int'(ball_tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // randomized play
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      ball_fell = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0: ball_top = 16'(MID - 1);
        1: ball_top = 16'(MID);
        default: ball_top = 16'($urandom_range(0, 600));
      endcase
    end
    start = 1'b0; pause = 1'b0; ball_fell = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
